// File: rtl/comp_serial_pkg.sv
// ============================================================================
// Module   : comp_serial_pkg
// Brief    : Shared constants for the serial magnitude-compare controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comp_serial_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // Bit positions inside the packed result register
  localparam int R_GT = 2;
  localparam int R_EQ = 1;
  localparam int R_LT = 0;

endpackage

`default_nettype wire

// File: rtl/comp_bit_cell.sv
// ============================================================================
// Module   : comp_bit_cell
// Brief    : Combinational 1-bit magnitude-compare cascade cell (MSB first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_bit_cell (
  input  logic a,
  input  logic b,
  input  logic gin,
  input  logic ein,
  input  logic lin,
  output logic gout,
  output logic eout,
  output logic lout
);

  // Only the first differing bit (while still equal so far) decides the outcome
  assign gout = gin | (ein & a & ~b);
  assign lout = lin | (ein & ~a & b);
  assign eout = ein & ~(a ^ b);

endmodule

`default_nettype wire

// File: rtl/comp_serial_ctrl.sv
// ============================================================================
// Module   : comp_serial_ctrl
// Brief    : Sequential W-bit magnitude comparator, one bit per clock, MSB
//            first, with start/done handshake. Optional macro
//            COMP_SERIAL_EARLY_EXIT_EN finishes on the first differing bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_serial_ctrl
  import comp_serial_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam logic [CNT_W-1:0] C_IDX_TOP = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_g;
  logic             r_e;
  logic             r_l;
  logic [2:0]       r_res;
  logic             w_gout;
  logic             w_eout;
  logic             w_lout;
  logic             w_accept;
  logic             w_last;

  comp_bit_cell u_cell (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .gin  (r_g),
    .ein  (r_e),
    .lin  (r_l),
    .gout (w_gout),
    .eout (w_eout),
    .lout (w_lout)
  );

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef COMP_SERIAL_EARLY_EXIT_EN
  // Once a bit differs the verdict is fixed; the remaining bits cannot change it
  assign w_last = (r_idx == '0) || !w_eout;
`else
  assign w_last = (r_idx == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= C_IDX_TOP;
      r_a   <= '0;
      r_b   <= '0;
      r_g   <= 1'b0;
      r_e   <= 1'b1;
      r_l   <= 1'b0;
      r_res <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_idx <= C_IDX_TOP;
      r_g   <= 1'b0;
      r_e   <= 1'b1;
      r_l   <= 1'b0;
      r_res <= '0;
    end else if (r_state == ST_RUN) begin
      r_g <= w_gout;
      r_e <= w_eout;
      r_l <= w_lout;
      if (w_last) begin
        // Results are captured from the final cell step so they are valid with done
        r_res[R_GT] <= w_gout;
        r_res[R_EQ] <= w_eout;
        r_res[R_LT] <= w_lout;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign gt   = r_res[R_GT];
  assign eq   = r_res[R_EQ];
  assign lt   = r_res[R_LT];

endmodule

`default_nettype wire

// File: tb/tb_comp_serial_ctrl.sv
// ============================================================================
// Module   : tb_comp_serial_ctrl
// Brief    : Self-checking bench for comp_serial_ctrl (W=4), scoreboard based.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_serial_ctrl;

  localparam int W = 4;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  comp_serial_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef COMP_SERIAL_EARLY_EXIT_EN
    if (x != y) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (x[i] != y[i]) return (W - 1 - i) + 2;
      end
    end
`endif
    return W + 1;
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.gt  = (x > y);
    e.eq  = (x == y);
    e.lt  = (x < y);
    e.lat = exp_lat(x, y);
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, gt, eq, lt} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b exp=00000", {busy, done, gt, eq, lt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One operation; latency counted from the accept cycle (cycle 0)
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t p;
    int   k;
    bit   got;
    int   busy_bad;
    q.push_back(model(x, y));
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    k = 0; got = 0; busy_bad = 0;
    while (!got && k < 4 * W + 8) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      a = ~x;
      b = W'($urandom);
      if (done) got = 1;
      else if (busy !== 1'b1) busy_bad++;
    end
    p = q.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL done_timeout a=%0d b=%0d got=no_done exp=done_at_%0d", x, y, p.lat);
    end else begin
      if (k != p.lat) begin
        n_err++;
        $display("FAIL latency a=%0d b=%0d got=%0d exp=%0d", x, y, k, p.lat);
      end
      n_cmp++;
      if ({gt, eq, lt} !== {p.gt, p.eq, p.lt} || !$onehot({gt, eq, lt})) begin
        n_err++;
        $display("FAIL result a=%0d b=%0d got=%b exp=%b", x, y, {gt, eq, lt}, {p.gt, p.eq, p.lt});
      end
      n_cmp++;
      if (busy_bad != 0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy a=%0d b=%0d got_low_cycles=%0d busy_at_done=%b exp=0,0", x, y, busy_bad, busy);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, gt, eq, lt} !== {1'b0, p.gt, p.eq, p.lt}) begin
        n_err++;
        $display("FAIL done_pulse_hold a=%0d b=%0d got=%b exp=%b", x, y, {done, gt, eq, lt}, {1'b0, p.gt, p.eq, p.lt});
      end
    end
  endtask

  task automatic test_vectors;
    run_op(4'b1001, 4'b0110);
    run_op(4'd5, 4'd5);
    run_op(4'b0100, 4'b0101);
  endtask

  task automatic test_back_to_back;
    exp_t         e;
    exp_t         p;
    int           t;
    logic [W-1:0] ox;
    logic [W-1:0] oy;
    // Predict accepts while start is held for cycles 0..6, operands swap at cycle 2
    t = 0;
    while (t <= 6) begin
      ox = (t >= 2) ? 4'd9 : 4'd3;
      oy = (t >= 2) ? 4'd2 : 4'd7;
      e = model(ox, oy);
      e.lat = t + exp_lat(ox, oy);
      q.push_back(e);
      t = t + exp_lat(ox, oy) + 1;
    end
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra_done cycle=%0d got=done exp=none", c);
        end else begin
          p = q.pop_front();
          if (c != p.lat || {gt, eq, lt} !== {p.gt, p.eq, p.lt}) begin
            n_err++;
            $display("FAIL b2b_op got=cycle%0d/%b exp=cycle%0d/%b", c, {gt, eq, lt}, p.lat, {p.gt, p.eq, p.lt});
          end
        end
      end
      start = (c <= 6);
      a = (c >= 2) ? 4'd9 : 4'd3;
      b = (c >= 2) ? 4'd2 : 4'd7;
    end
    start = 1'b0;
    while (q.size() != 0) begin
      p = q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL b2b_missing_done got=none exp=done_at_cycle%0d", p.lat);
    end
  endtask

  task automatic test_reset_midrun;
    int extra;
    @(negedge clk);
    a = 4'd5; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, gt, eq, lt} !== 5'b0) begin
      n_err++;
      $display("FAIL midrun_reset got=%b exp=00000", {busy, done, gt, eq, lt});
    end
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL midrun_no_done got=%0d_active_cycles exp=0", extra);
    end
    run_op(4'd9, 4'd3);
  endtask

  task automatic test_sweep;
    logic [7:0] pair;
    int         base;
    base = $urandom_range(0, 255);
    // Odd multiplier gives a permutation of all 256 pairs
    for (int i = 0; i < 256; i++) begin
      pair = 8'((i * 167 + base) % 256);
      run_op(pair[7:4], pair[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
